// File: rtl/im.sv
// im: byte-addressed instruction memory returning big-endian 32-bit words from any byte address.
// Optional macro IM_REG_OUT_EN registers Instr/AddrErr (one cycle read latency, cleared by rst).
module im #(
   parameter int unsigned INSTR_MAX  = 128,
   parameter int unsigned INSTR_SIZE = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] InstrAddr,
   output logic [31:0] Instr,
   output logic        AddrErr,
   input  logic        LoadEn,
   input  logic [31:0] LoadAddr,
   input  logic [31:0] LoadData,
   input  logic [3:0]  LoadBe
);

   localparam int unsigned AW = (INSTR_MAX > 1) ? $clog2(INSTR_MAX) : 1;
   localparam int unsigned NB = 4;

   logic [INSTR_SIZE-1:0] InstrMem [INSTR_MAX];

   logic          w_rd_ok;
   logic [AW-1:0] w_rd_base;
   logic [31:0]   w_rd_word;
   logic [31:0]   w_rd_instr;
   logic          w_rd_err;

   logic [NB-1:0] w_we;
   logic [AW-1:0] w_widx  [NB];
   logic [7:0]    w_wbyte [NB];

   // Whole word must fit; the full 32-bit compare rejects any nonzero upper bits.
   assign w_rd_ok   = (InstrAddr <= 32'(INSTR_MAX - NB));
   assign w_rd_base = InstrAddr[AW-1:0];

   always_comb begin
      w_rd_word = '0;
      for (int unsigned k = 0; k < NB; k++) begin
         w_rd_word[31-8*k -: 8] = 8'(InstrMem[w_rd_base + AW'(k)]);
      end
   end

   assign w_rd_instr = w_rd_ok ? w_rd_word : 32'h0000_0000;
   assign w_rd_err   = ~w_rd_ok;

   // Per-byte write decode; range compare is done before indexing so nothing wraps.
   always_comb begin
      w_we    = '0;
      w_widx  = '{default: '0};
      w_wbyte = '{default: '0};
      for (int unsigned k = 0; k < NB; k++) begin
         w_we[k]    = LoadEn && !rst && LoadBe[NB-1-k] &&
                      (LoadAddr < (32'(INSTR_MAX) - 32'(k)));
         w_widx[k]  = LoadAddr[AW-1:0] + AW'(k);
         w_wbyte[k] = LoadData[31-8*k -: 8];
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned k = 0; k < NB; k++) begin
         if (w_we[k]) begin
            InstrMem[w_widx[k]] <= INSTR_SIZE'(w_wbyte[k]);
         end
      end
   end

`ifdef IM_REG_OUT_EN
   logic [31:0] r_instr;
   logic        r_addr_err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_instr    <= '0;
         r_addr_err <= 1'b0;
      end else begin
         r_instr    <= w_rd_instr;
         r_addr_err <= w_rd_err;
      end
   end

   assign Instr   = r_instr;
   assign AddrErr = r_addr_err;
`else
   assign Instr   = w_rd_instr;
   assign AddrErr = w_rd_err;
`endif

endmodule

// File: tb/tb_im.sv
// tb_im: randomized self-checking bench for im against a byte-array reference model.
module tb_im;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] InstrAddr = '0;
   logic [31:0] Instr;
   logic        AddrErr;
   logic        LoadEn = 1'b0;
   logic [31:0] LoadAddr = '0;
   logic [31:0] LoadData = '0;
   logic [3:0]  LoadBe = '0;

   int n_checks = 0;
   int n_fail   = 0;

   logic [7:0]  mem_m [128];
   logic [32:0] exp_r = '0;

   im #(.INSTR_MAX(128), .INSTR_SIZE(8)) Instruction_Memory (
      .clk(clk), .rst(rst), .InstrAddr(InstrAddr), .Instr(Instr), .AddrErr(AddrErr),
      .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData), .LoadBe(LoadBe)
   );

   always #5 clk = ~clk;

   // {AddrErr, Instr} as the rules define them for the current model contents.
   function automatic logic [32:0] model_read(input logic [31:0] a);
      logic [6:0] i;
      if (a > 32'd124) return {1'b1, 32'h0};
      i = a[6:0];
      return {1'b0, mem_m[i], mem_m[i + 7'd1], mem_m[i + 7'd2], mem_m[i + 7'd3]};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic poke(input int a, input logic [7:0] b);
      mem_m[7'(a)] = b;
      Instruction_Memory.InstrMem[7'(a)] = b;
   endtask

   task automatic apply_load();
      for (int k = 0; k < 4; k++) begin
         if (LoadBe[3-k] && (longint'(LoadAddr) + longint'(k) < 128))
            mem_m[7'(LoadAddr + 32'(k))] = LoadData[31-8*k -: 8];
      end
   endtask

   // Cross one rising edge, advancing the model exactly as the edge does.
   task automatic step();
      @(posedge clk);
      if (rst) exp_r = '0;
      else begin
         exp_r = model_read(InstrAddr);
         if (LoadEn) apply_load();
      end
      #1;
   endtask

   always @(negedge clk) begin
      logic [32:0] e;
`ifdef IM_REG_OUT_EN
      e = exp_r;
`else
      e = model_read(InstrAddr);
`endif
      chk("cyc_instr", Instr, e[31:0]);
      chk("cyc_err", {31'b0, AddrErr}, {31'b0, e[32]});
   end

   initial begin
      for (int i = 0; i < 128; i++) poke(i, 8'($urandom));
      poke(8, 8'h12);  poke(9, 8'h32);  poke(10, 8'hB0); poke(11, 8'h12);
      poke(2, 8'hA0);  poke(3, 8'h0B);  poke(4, 8'h11);  poke(5, 8'hAC);
      poke(124, 8'h01); poke(125, 8'h02); poke(126, 8'h03); poke(127, 8'h04);
      #1;
`ifndef IM_REG_OUT_EN
      // Combinational reads, no clock edge involved; rst is high and must not matter.
      InstrAddr = 32'd8;          #1; chk("lit_a8", Instr, 32'h1232B012);
      chk("lit_a8_err", {31'b0, AddrErr}, 32'd0);
      InstrAddr = 32'd2;          #1; chk("lit_a2", Instr, 32'hA00B11AC);
      InstrAddr = 32'd125;        #1; chk("lit_a125", Instr, 32'h0);
      chk("lit_a125_err", {31'b0, AddrErr}, 32'd1);
      InstrAddr = 32'h0001_0000;  #1; chk("lit_hi", Instr, 32'h0);
      chk("lit_hi_err", {31'b0, AddrErr}, 32'd1);
      InstrAddr = 32'd124;        #1; chk("lit_a124", Instr, 32'h01020304);
      chk("lit_a124_err", {31'b0, AddrErr}, 32'd0);
`else
      chk("lit_rst_instr", Instr, 32'h0);
      chk("lit_rst_err", {31'b0, AddrErr}, 32'd0);
`endif
      step();
      rst = 1'b0;
`ifdef IM_REG_OUT_EN
      InstrAddr = 32'd8;  step();  chk("lit_reg_a8", Instr, 32'h1232B012);
      InstrAddr = 32'd2;  #1;      chk("lit_reg_hold", Instr, 32'h1232B012);
      step();                      chk("lit_reg_a2", Instr, 32'hA00B11AC);
      rst = 1'b1; exp_r = '0; #1;  chk("lit_reg_rst", Instr, 32'h0);
      rst = 1'b0; #1;              chk("lit_reg_rst_hold", Instr, 32'h0);
      step();                      chk("lit_reg_restore", Instr, 32'hA00B11AC);
`endif
      // Byte-enabled load over zeros, then a partially out-of-range word.
      LoadEn = 1'b1; LoadAddr = 32'd16; LoadData = 32'h0; LoadBe = 4'b1111; step();
      LoadData = 32'hDEADBEEF; LoadBe = 4'b1010; step();
      LoadEn = 1'b0; InstrAddr = 32'd16; step(); step();
      chk("lit_be1010", Instr, 32'hDE00BE00);
      LoadEn = 1'b1; LoadAddr = 32'd126; LoadData = 32'h11223344; LoadBe = 4'b1111; step();
      LoadEn = 1'b0; InstrAddr = 32'd124; step(); step();
      chk("lit_tail_load", Instr, 32'h01021122);
      chk("lit_tail_err", {31'b0, AddrErr}, 32'd0);
      InstrAddr = 32'd125; step(); step();
      chk("lit_a125_err2", {31'b0, AddrErr}, 32'd1);

      for (int c = 0; c < 800; c++) begin
         if (rst) rst = 1'b0;
         case ($urandom_range(0, 9))
            0:       InstrAddr = $urandom | 32'h0000_0100;
            default: InstrAddr = 32'($urandom_range(0, 130));
         endcase
         LoadEn = ($urandom_range(0, 2) == 0);
         case ($urandom_range(0, 7))
            0:       LoadAddr = InstrAddr;
            1:       LoadAddr = 32'hFFFF_FFFE;
            default: LoadAddr = 32'($urandom_range(0, 130));
         endcase
         LoadData = $urandom;
         LoadBe   = 4'($urandom);
         case ($urandom_range(0, 59))
            0: begin rst = 1'b1; exp_r = '0; #2; rst = 1'b0; end
            1: begin rst = 1'b1; exp_r = '0; end
            default: ;
         endcase
         step();
      end
      rst = 1'b0;
      LoadEn = 1'b0;
      step(); step();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
